// File: rtl/traffic_sensor_cond_pkg.sv
// traffic_sensor_cond_pkg: shared constants and types for the sensor conditioner and light controller
package traffic_sensor_cond_pkg;
    localparam int DB_CYC_DEF = 4;
    localparam int CNT_W = 8;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, RED = 2'd2} light_t;
endpackage

// File: rtl/traffic_sensor_cond_debounce.sv
// tl_debounce: 2-flop synchronizer plus counter debouncer, emitting either the level or its rise pulse
module tl_debounce
    import traffic_sensor_cond_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEF,
    parameter bit EDGE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic q
);
    localparam cnt_t LAST = cnt_t'(DB_CYC - 1);
    logic s1, s, d, rise, flip;
    cnt_t cnt;
    assign flip = (s != d) && (cnt == LAST);
    assign q = EDGE ? rise : d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s    <= 1'b0;
            d    <= 1'b0;
            rise <= 1'b0;
            cnt  <= '0;
        end else begin
            s1   <= raw;
            s    <= s1;
            d    <= flip ? s : d;
            // rise is set on the same edge d goes 0->1, so it is visible the cycle after
            rise <= flip & s;
            cnt  <= (s == d || flip) ? '0 : cnt + 1'b1;
        end
    end
endmodule

// File: rtl/traffic_sensor_cond.sv
// traffic_sensor_cond: debounces car sensors and parade buttons; release wins over start on collision
module traffic_sensor_cond
    import traffic_sensor_cond_pkg::*;
#(
    parameter int DB_CYC = DB_CYC_DEF
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_raw_TA,
    input  logic i_raw_TB,
    input  logic i_btn_P,
    input  logic i_btn_R,
    output logic o_TA,
    output logic o_TB,
    output logic o_P,
    output logic o_R
);
    logic p, r;
    tl_debounce #(.DB_CYC(DB_CYC), .EDGE(1'b0)) u_ta (.clk(i_clk), .rst_n(i_rstn), .raw(i_raw_TA), .q(o_TA));
    tl_debounce #(.DB_CYC(DB_CYC), .EDGE(1'b0)) u_tb (.clk(i_clk), .rst_n(i_rstn), .raw(i_raw_TB), .q(o_TB));
    tl_debounce #(.DB_CYC(DB_CYC), .EDGE(1'b1)) u_p  (.clk(i_clk), .rst_n(i_rstn), .raw(i_btn_P),  .q(p));
    tl_debounce #(.DB_CYC(DB_CYC), .EDGE(1'b1)) u_r  (.clk(i_clk), .rst_n(i_rstn), .raw(i_btn_R),  .q(r));
    assign o_R = r;
    assign o_P = p & ~r;
endmodule

// File: doc/traffic_sensor_cond.md
TRAFFIC_SENSOR_COND -- requirements
Module: traffic_sensor_cond

Interface
REQ-001 Parameter DB_CYC, default 4: consecutive cycles a synchronized input must differ from its debounced value before that value updates; legal range 1..255.
REQ-002 i_clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 i_rstn  input  1  reset, asynchronous, active-low.
REQ-004 i_raw_TA  input  1  raw, asynchronous car sensor for street A.
REQ-005 i_raw_TB  input  1  raw, asynchronous car sensor for street B.
REQ-006 i_btn_P  input  1  raw, asynchronous parade-start button.
REQ-007 i_btn_R  input  1  raw, asynchronous parade-release button.
REQ-008 o_TA  output  1  debounced level of i_raw_TA, drives controller i_TA.
REQ-009 o_TB  output  1  debounced level of i_raw_TB, drives controller i_TB.
REQ-010 o_P  output  1  one-cycle pulse on debounced rising edge of i_btn_P, drives controller i_P.
REQ-011 o_R  output  1  one-cycle pulse on debounced rising edge of i_btn_R, drives controller i_R.

Function
REQ-012 Each raw input SHALL pass through a 2-flop synchronizer; the second flop is the synchronized value s.
REQ-013 Each channel SHALL hold a debounced value d and a counter cnt (8 bits).
REQ-014 Per edge: s==d -> cnt<=0; s!=d and cnt==DB_CYC-1 -> d<=s, cnt<=0; otherwise cnt<=cnt+1.
REQ-015 A raw level change held stable SHALL appear on d at the (DB_CYC+2)-th rising edge, counting the first edge that samples the new level (DB_CYC=4 -> 6th edge).
REQ-016 A raw pulse or glitch whose synchronized width is shorter than DB_CYC cycles SHALL NOT change d; cnt returns to 0 when s re-matches d.
REQ-017 DB_CYC=1 SHALL update d on the first edge where s!=d (latency 3 edges).
REQ-018 cnt SHALL never exceed DB_CYC-1 and SHALL never wrap.
REQ-019 o_TA/o_TB SHALL be registered d of their channels, with no additional delay.
REQ-020 o_P SHALL be 1 for exactly the one cycle following the edge where d_P goes 0->1; likewise o_R for d_R.
REQ-021 A button held indefinitely SHALL produce one pulse only; a further pulse requires debounced release then re-press.
REQ-022 If o_P and o_R would assert in the same cycle, o_R SHALL assert and o_P SHALL be suppressed (dropped, not deferred).
REQ-023 Channels SHALL be fully independent apart from REQ-022.

Reset
REQ-024 While i_rstn=0: all synchronizer flops, d, cnt and edge-history flops SHALL be 0 asynchronously; o_TA=o_TB=o_P=o_R=0.
REQ-025 Reset asserted mid-debounce SHALL discard the partial count; after release, a held-high input SHALL take the full REQ-015 latency.
REQ-026 A button held high through reset release SHALL produce one o_P/o_R pulse once debounced (the edge history resets to 0).

Structure
REQ-027 A shared header SHALL hold DB_CYC default and counter width; the controller light encoding (GREEN=0, YELLOW=1, RED=2) stays in the same header.
REQ-028 One sub-module, tl_debounce (synchronizer + counter + d + optional rise pulse), SHALL be instantiated four times; the top adds only the REQ-022 arbitration.
REQ-029 No combinational path SHALL exist from any raw input to any output.

Verification
REQ-030 Reset, i_raw_TA 0->1 held, DB_CYC=4 -> o_TA=1 at 6th edge after first sample, not at 5th.
REQ-031 i_raw_TB high for 3 cycles then low, DB_CYC=4 -> o_TB stays 0 and internal cnt returns to 0.
REQ-032 i_btn_P held high for 20 cycles -> exactly one o_P pulse, 1 cycle wide, at edge 6 plus 1 cycle.
REQ-033 i_btn_P and i_btn_R rise on the same edge -> o_R pulses once, o_P stays 0 throughout.
REQ-034 i_raw_TA high, i_rstn pulsed low after 3 cycles -> all outputs 0 immediately; o_TA=1 six edges after release.
REQ-035 Random 4-bit stimulus on all raw inputs for 100 cycles -> a reference model of REQ-014/020/022 matches all outputs every cycle.
